// File: rtl/dot_matrix_scan_decoder_pkg.sv
// Shared constants for the dot-matrix / 7-segment receive decoder:
// reference glyphs, glyph id encodings, collector states and the
// active-low segment lookup.
package dot_matrix_scan_decoder_pkg;

  // Reference glyphs, row 0 in the top byte.
  localparam logic [63:0] GLYPH_GREEN  = 64'h3030_987E_1918_1412;
  localparam logic [63:0] GLYPH_YELLOW = 64'h0024_3CBD_FF3C_3C00;
  localparam logic [63:0] GLYPH_RED    = 64'h1818_3C3C_5A18_1824;

  localparam logic [1:0] GLYPH_ID_GREEN   = 2'd0;
  localparam logic [1:0] GLYPH_ID_YELLOW  = 2'd1;
  localparam logic [1:0] GLYPH_ID_RED     = 2'd2;
  localparam logic [1:0] GLYPH_ID_UNKNOWN = 2'd3;

  // Frame collector states.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Collector state as seen on the debug port.
  typedef struct packed {
    logic [0:0] state;
    logic [2:0] expected;
  } collector_dbg_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } seg_decode_t;

  // Active-low segment code (bit6 = g .. bit0 = a) to hex digit.
  function automatic seg_decode_t seg_lookup(input logic [6:0] code_al);
    seg_decode_t r;
    r.valid = 1'b1;
    r.digit = 4'h0;
    case (code_al)
      7'h40: r.digit = 4'h0;
      7'h79: r.digit = 4'h1;
      7'h24: r.digit = 4'h2;
      7'h30: r.digit = 4'h3;
      7'h19: r.digit = 4'h4;
      7'h12: r.digit = 4'h5;
      7'h02: r.digit = 4'h6;
      7'h78: r.digit = 4'h7;
      7'h00: r.digit = 4'h8;
      7'h10: r.digit = 4'h9;
      7'h08: r.digit = 4'hA;
      7'h03: r.digit = 4'hB;
      7'h46: r.digit = 4'hC;
      7'h21: r.digit = 4'hD;
      7'h06: r.digit = 4'hE;
      7'h0E: r.digit = 4'hF;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // Exact match of a full frame against the reference glyphs.
  function automatic logic [1:0] classify_frame(input logic [63:0] f);
    logic [1:0] c;
    if (f == GLYPH_GREEN)       c = GLYPH_ID_GREEN;
    else if (f == GLYPH_YELLOW) c = GLYPH_ID_YELLOW;
    else if (f == GLYPH_RED)    c = GLYPH_ID_RED;
    else                        c = GLYPH_ID_UNKNOWN;
    return c;
  endfunction

endpackage

// File: rtl/dot_matrix_scan_decoder_seg7_decoder.sv
// Registered 7-segment decoder: code -> digit plus a legal-code flag.
// An illegal code drops the flag and keeps the last decoded digit.
module seg7_decoder
  import dot_matrix_scan_decoder_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_code,
  output logic [3:0] o_value,
  output logic       o_valid
);

  logic [6:0]  w_code_al;
  seg_decode_t w_dec;

  assign w_code_al = SEG_ACTIVE_LOW ? i_code : ~i_code;
  assign w_dec     = seg_lookup(w_code_al);

  // Register the lookup; digit only follows legal codes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_value <= 4'h0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= w_dec.valid;
      if (w_dec.valid) o_value <= w_dec.digit;
    end
  end

endmodule

// File: rtl/dot_matrix_scan_decoder.sv
// Receive-side decoder for the traffic-light display bus: rebuilds
// 8x8 frames from the row scan, classifies and debounces the glyph,
// decodes the countdown digit and flags protocol errors.
// All outputs named *_valid, *_change and *_err are single-cycle pulses
// with no back-pressure; seg_valid is a level.
module dot_matrix_scan_decoder
  import dot_matrix_scan_decoder_pkg::*;
#(
  parameter int MATCH_FRAMES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     dot_row,
  input  logic [7:0]     dot_column,
  input  logic [6:0]     seven_display,
  output logic [63:0]    frame_out,
  output logic           frame_valid,
  output logic [1:0]     glyph_id,
  output logic           glyph_change,
  output logic [3:0]     seg_value,
  output logic           seg_valid,
  output logic           row_err,
  output logic           seq_err,
  output logic           count_err,
  output collector_dbg_t o_dbg_collector
);

  localparam logic [3:0] MATCH_N   = 4'(MATCH_FRAMES);
  // Idle code: all segments dark, so nothing decodes before real input.
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [7:0]  r_row, r_col, r_row_prev;
  logic [6:0]  r_seg;
  logic        r_in_vld, r_prev_vld;
  logic [0:0]  r_state;
  logic [2:0]  r_expected;
  logic [7:0]  r_buf [8];
  logic [1:0]  r_last_class;
  logic [3:0]  r_run;
  logic [3:0]  r_last_val;
  logic        r_have_last;

  logic        w_evt;
  logic [3:0]  w_zero_cnt;
  logic [2:0]  w_row_idx;
  logic        w_row_legal, w_row_blank, w_row_bad;
  logic [0:0]  w_state_nxt;
  logic [2:0]  w_exp_nxt;
  logic        w_wr_en, w_commit, w_seq_err;
  logic [63:0] w_frame_new;
  logic [1:0]  w_class;
  logic [3:0]  w_run_inc, w_run_nxt;

  // Input stage, plus the previous registered row for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row      <= 8'hFF;
      r_col      <= 8'h00;
      r_seg      <= SEG_BLANK;
      r_in_vld   <= 1'b0;
      r_row_prev <= 8'hFF;
      r_prev_vld <= 1'b0;
    end else begin
      r_row      <= dot_row;
      r_col      <= dot_column;
      r_seg      <= seven_display;
      r_in_vld   <= 1'b1;
      r_row_prev <= r_row;
      r_prev_vld <= r_in_vld;
    end
  end

  // A sample event is a change of the registered row select, or the
  // first registered value after reset.
  assign w_evt = r_in_vld && (!r_prev_vld || (r_row != r_row_prev));

  // Count active-low select bits; bit 7 low is row 0.
  always_comb begin
    w_zero_cnt = 4'd0;
    w_row_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!r_row[i]) begin
        w_zero_cnt = w_zero_cnt + 4'd1;
        w_row_idx  = 3'(7 - i);
      end
    end
  end

  assign w_row_legal = (w_zero_cnt == 4'd1);
  assign w_row_blank = (r_row == 8'h00) || (r_row == 8'hFF);
  assign w_row_bad   = !w_row_legal && !w_row_blank;

  // Collector next-state: in-order rows fill the buffer, row 7 commits.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_seq_err   = 1'b0;
    if (w_evt) begin
      if (w_row_legal) begin
        if (r_state == ST_IDLE) begin
          if (w_row_idx == 3'd0) begin
            w_wr_en     = 1'b1;
            w_exp_nxt   = 3'd1;
            w_state_nxt = ST_COLLECT;
          end
        end else if (w_row_idx == r_expected) begin
          w_wr_en   = 1'b1;
          w_exp_nxt = r_expected + 3'd1;
          if (r_expected == 3'd7) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_seq_err = 1'b1;
          if (w_row_idx == 3'd0) begin
            w_wr_en   = 1'b1;
            w_exp_nxt = 3'd1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end else begin
        // Blank or malformed select both abandon the partial frame.
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // Collector state and expected-row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_expected <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_exp_nxt;
    end
  end

  // Row buffer writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
    end else if (w_wr_en) begin
      r_buf[w_row_idx] <= r_col;
    end
  end

  // Frame being committed: buffered rows 0..6 plus row 7 arriving now.
  always_comb begin
    w_frame_new = 64'h0;
    for (int i = 0; i < 7; i++) w_frame_new[63 - 8*i -: 8] = r_buf[i];
    w_frame_new[7:0] = r_col;
  end

  assign w_class   = classify_frame(w_frame_new);
  assign w_run_inc = (r_run == 4'hF) ? 4'hF : r_run + 4'd1;
  assign w_run_nxt = ((w_class == r_last_class) && (r_run != 4'd0)) ? w_run_inc : 4'd1;

  // Frame commit, class debounce and scan error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_out    <= 64'h0;
      frame_valid  <= 1'b0;
      glyph_id     <= GLYPH_ID_UNKNOWN;
      glyph_change <= 1'b0;
      r_last_class <= GLYPH_ID_UNKNOWN;
      r_run        <= 4'd0;
      row_err      <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      frame_valid  <= w_commit;
      glyph_change <= 1'b0;
      row_err      <= w_evt && w_row_bad;
      seq_err      <= w_seq_err;
      if (w_commit) begin
        frame_out    <= w_frame_new;
        r_last_class <= w_class;
        r_run        <= w_run_nxt;
        if ((w_run_nxt >= MATCH_N) && (w_class != glyph_id)) begin
          glyph_id     <= w_class;
          glyph_change <= 1'b1;
        end
      end
    end
  end

  seg7_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_seg7 (
    .clk    (clk),
    .reset  (reset),
    .i_code (r_seg),
    .o_value(seg_value),
    .o_valid(seg_valid)
  );

  // Countdown check against the last legal digit; 0 may reload anything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_val  <= 4'h0;
      r_have_last <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      count_err <= 1'b0;
      if (seg_valid) begin
        if (r_have_last && (seg_value != r_last_val) &&
            (r_last_val != 4'h0) && (seg_value != r_last_val - 4'd1))
          count_err <= 1'b1;
        r_last_val  <= seg_value;
        r_have_last <= 1'b1;
      end
    end
  end

  assign o_dbg_collector = {r_state, r_expected};

endmodule

// File: tb/tb_dot_matrix_scan_decoder.sv
// Bench for dot_matrix_scan_decoder: directed scans, a table of
// 7-segment vectors, reset mid-frame, and randomized row/segment
// traffic checked against a queue-based reference model.
module tb_dot_matrix_scan_decoder;

  localparam int MATCH_FRAMES = 2;

  localparam logic [63:0] G_GREEN  = 64'h3030987E19181412;
  localparam logic [63:0] G_YELLOW = 64'h00243CBDFF3C3C00;
  localparam logic [63:0] G_RED    = 64'h18183C3C5A181824;

  logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dot_row = 8'hFF;
  logic [7:0]  dot_column = 8'h00;
  logic [6:0]  seven_display = 7'h7F;
  logic [63:0] frame_out;
  logic        frame_valid, glyph_change, seg_valid, row_err, seq_err, count_err;
  logic [1:0]  glyph_id;
  logic [3:0]  seg_value;
  logic [3:0]  dbg;

  always #5 clk = ~clk;

  dot_matrix_scan_decoder #(.MATCH_FRAMES(MATCH_FRAMES), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .dot_row        (dot_row),
    .dot_column     (dot_column),
    .seven_display  (seven_display),
    .frame_out      (frame_out),
    .frame_valid    (frame_valid),
    .glyph_id       (glyph_id),
    .glyph_change   (glyph_change),
    .seg_value      (seg_value),
    .seg_valid      (seg_valid),
    .row_err        (row_err),
    .seq_err        (seq_err),
    .count_err      (count_err),
    .o_dbg_collector(dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Observed pulse counts.
  int n_fv = 0, n_gc = 0, n_re = 0, n_se = 0, n_ce = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) begin
        n_fv++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_out: unexpected frame actual=%h", frame_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("frame_out", frame_out, mon_exp);
        end
      end
      if (glyph_change) n_gc++;
      if (row_err)      n_re++;
      if (seq_err)      n_se++;
      if (count_err)    n_ce++;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_part[$];      // rows collected so far in the current frame
  bit         m_active = 0;
  logic [1:0] m_hist[$];      // class of every completed frame since reset
  logic [1:0] exp_glyph = 2'd3;
  int         exp_fv = 0, exp_gc = 0, exp_re = 0, exp_se = 0, exp_ce = 0;
  int         m_last_seg = -1;
  logic [3:0] exp_seg_val = 4'h0;
  logic       exp_seg_vld = 1'b0;
  logic [7:0] last_sel = 8'hFF;

  task automatic model_frame();
    logic [63:0] f;
    logic [1:0]  c;
    int          run;
    f = 64'h0;
    for (int i = 0; i < 8; i++) f[63 - 8*i -: 8] = m_part[i];
    exp_q.push_back(f);
    exp_fv++;
    if (f == G_GREEN)       c = 2'd0;
    else if (f == G_YELLOW) c = 2'd1;
    else if (f == G_RED)    c = 2'd2;
    else                    c = 2'd3;
    m_hist.push_back(c);
    run = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != c) break;
      run++;
    end
    if (run >= MATCH_FRAMES && c != exp_glyph) begin
      exp_glyph = c;
      exp_gc++;
    end
  endtask

  task automatic model_row(input logic [7:0] sel, input logic [7:0] col);
    int zeros, idx;
    zeros = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) if (!sel[i]) begin zeros++; idx = 7 - i; end
    if (zeros == 1) begin
      if (!m_active) begin
        if (idx == 0) begin m_part.delete(); m_part.push_back(col); m_active = 1; end
      end else if (idx == m_part.size()) begin
        m_part.push_back(col);
        if (m_part.size() == 8) begin model_frame(); m_active = 0; end
      end else begin
        exp_se++;
        if (idx == 0) begin m_part.delete(); m_part.push_back(col); end
        else m_active = 0;
      end
    end else if (sel == 8'h00 || sel == 8'hFF) begin
      m_active = 0;
    end else begin
      exp_re++;
      m_active = 0;
    end
  endtask

  task automatic model_seg(input logic [6:0] code);
    int d;
    d = -1;
    for (int i = 0; i < 16; i++) if (seg_al[i] == code) d = i;
    if (d >= 0) begin
      if (m_last_seg >= 0 && d != m_last_seg && m_last_seg != 0 && d != m_last_seg - 1)
        exp_ce++;
      m_last_seg  = d;
      exp_seg_val = 4'(d);
      exp_seg_vld = 1'b1;
    end else begin
      exp_seg_vld = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_part.delete();
    m_hist.delete();
    exp_q.delete();
    exp_glyph   = 2'd3;
    m_last_seg  = -1;
    exp_seg_val = 4'h0;
    exp_seg_vld = 1'b0;
    last_sel    = 8'hFF;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_row(input logic [7:0] sel, input logic [7:0] col, input int hold);
    dot_row    = sel;
    dot_column = col;
    if (sel != last_sel) model_row(sel, col);
    last_sel = sel;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic apply_seg(input logic [6:0] code, input int hold);
    seven_display = code;
    model_seg(code);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic scan_rows(input logic [63:0] fr, input int first, input int last, input int hold);
    logic [7:0] sel;
    for (int r = first; r <= last; r++) begin
      sel = ~(8'h80 >> r);
      apply_row(sel, fr[63 - 8*r -: 8], hold);
    end
  endtask

  task automatic check_all(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, ".frames"},    64'(n_fv), 64'(exp_fv));
    check({tag, ".glyph_chg"}, 64'(n_gc), 64'(exp_gc));
    check({tag, ".row_err"},   64'(n_re), 64'(exp_re));
    check({tag, ".seq_err"},   64'(n_se), 64'(exp_se));
    check({tag, ".count_err"}, 64'(n_ce), 64'(exp_ce));
    check({tag, ".glyph_id"},  64'(glyph_id), 64'(exp_glyph));
    check({tag, ".seg_valid"}, 64'(seg_valid), 64'(exp_seg_vld));
    check({tag, ".seg_value"}, 64'(seg_value), 64'(exp_seg_val));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".frame_out"},    frame_out, 64'h0);
    check({tag, ".frame_valid"},  64'(frame_valid), 64'h0);
    check({tag, ".glyph_id"},     64'(glyph_id), 64'h3);
    check({tag, ".glyph_change"}, 64'(glyph_change), 64'h0);
    check({tag, ".seg_value"},    64'(seg_value), 64'h0);
    check({tag, ".seg_valid"},    64'(seg_valid), 64'h0);
    check({tag, ".errs"},         64'({row_err, seq_err, count_err}), 64'h0);
    check({tag, ".dbg"},          64'(dbg), 64'h0);
  endtask

  // Table of 7-segment vectors: {code, expected valid, value, count_err pulses}.
  typedef struct {
    logic [6:0] code;
    logic       exp_vld;
    logic [3:0] exp_val;
    int         exp_ce;
  } seg_vec_t;

  seg_vec_t seg_tbl[11];

  // ---------------- test sequence ----------------
  initial begin
    int         ce0, fv0, g, k, hold;
    logic [63:0] fr;
    logic [7:0]  sel, col;
    logic [6:0]  code;

    seg_tbl[0]  = '{7'h08, 1'b1, 4'hA, 0};  // first legal value, no history
    seg_tbl[1]  = '{7'h00, 1'b1, 4'h8, 1};  // A -> 8 skips 9
    seg_tbl[2]  = '{7'h10, 1'b1, 4'h9, 1};  // 8 -> 9 counts up
    seg_tbl[3]  = '{7'h7F, 1'b0, 4'h9, 0};  // blank code holds 9
    seg_tbl[4]  = '{7'h30, 1'b1, 4'h3, 1};  // 9 -> 3 across the gap
    seg_tbl[5]  = '{7'h24, 1'b1, 4'h2, 0};
    seg_tbl[6]  = '{7'h79, 1'b1, 4'h1, 0};
    seg_tbl[7]  = '{7'h40, 1'b1, 4'h0, 0};
    seg_tbl[8]  = '{7'h0E, 1'b1, 4'hF, 0};  // reload from 0
    seg_tbl[9]  = '{7'h7F, 1'b0, 4'hF, 0};
    seg_tbl[10] = '{7'h06, 1'b1, 4'hE, 0};  // F -> gap -> E

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // GREEN twice: two frames, glyph 3 -> 0 on the second.
    scan_rows(G_GREEN, 0, 7, 5);
    check("green1.glyph_id", 64'(glyph_id), 64'h3);
    scan_rows(G_GREEN, 0, 7, 5);
    check("green2.frame_out", frame_out, G_GREEN);
    check_all("green");
    check("green.glyph_id_const", 64'(glyph_id), 64'h0);

    // YELLOW, then rows 0,1,2,4 -> seq_err, collector idle; RED x2.
    scan_rows(G_YELLOW, 0, 7, 5);
    fv0 = n_fv;
    scan_rows(G_YELLOW, 0, 2, 5);
    scan_rows(G_YELLOW, 4, 4, 5);
    check_all("seq");
    check("seq.no_frame", 64'(n_fv - fv0), 64'h0);
    check("seq.dbg_idle", 64'(dbg[3]), 64'h0);
    scan_rows(G_RED, 0, 7, 5);
    scan_rows(G_RED, 0, 7, 5);
    check_all("red");
    check("red.glyph_id_const", 64'(glyph_id), 64'h2);

    // Malformed select mid-frame, then blank select mid-frame.
    scan_rows(G_GREEN, 0, 2, 3);
    apply_row(8'b00111111, 8'hAA, 3);
    scan_rows(G_GREEN, 3, 7, 3);
    check_all("rowerr");
    scan_rows(G_GREEN, 0, 3, 3);
    apply_row(8'h00, 8'h55, 3);
    scan_rows(G_GREEN, 4, 7, 3);
    check_all("blank");

    // 7-segment vectors.
    foreach (seg_tbl[i]) begin
      ce0 = n_ce;
      apply_seg(seg_tbl[i].code, 1);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("segtbl[%0d].valid", i), 64'(seg_valid), 64'(seg_tbl[i].exp_vld));
      check($sformatf("segtbl[%0d].value", i), 64'(seg_value), 64'(seg_tbl[i].exp_val));
      check($sformatf("segtbl[%0d].count_err", i), 64'(n_ce - ce0), 64'(seg_tbl[i].exp_ce));
    end
    check_all("segtbl");

    // Reset during row 4: partial frame lost, outputs back to reset values.
    apply_seg(7'h7F, 2);
    scan_rows(G_GREEN, 0, 4, 2);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    dot_row = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    fv0 = n_fv;
    scan_rows(G_GREEN, 5, 7, 3);
    check_all("after_reset");
    check("after_reset.no_frame", 64'(n_fv - fv0), 64'h0);
    scan_rows(G_GREEN, 0, 7, 3);
    check_all("after_reset_full");
    check("after_reset.one_frame", 64'(n_fv - fv0), 64'h1);

    // Randomized row scan traffic.
    g = 0;
    for (int f = 0; f < 80; f++) begin
      if (f % 2 == 0) g = $urandom_range(0, 3);
      fr = (g == 0) ? G_GREEN : (g == 1) ? G_YELLOW : (g == 2) ? G_RED
                                          : {$urandom, $urandom};
      for (int r = 0; r < 8; r++) begin
        hold = $urandom_range(1, 3);
        if ($urandom_range(0, 19) == 0) begin
          k   = $urandom_range(0, 3);
          col = 8'($urandom_range(0, 255));
          if (k == 0)      sel = ~(8'h80 >> $urandom_range(0, 7));
          else if (k == 1) sel = 8'h00;
          else if (k == 2) sel = 8'hFF;
          else begin
            do sel = 8'($urandom_range(0, 255));
            while ($countones(~sel) == 1 || sel == 8'h00 || sel == 8'hFF);
          end
        end else begin
          sel = ~(8'h80 >> r);
          col = fr[63 - 8*r -: 8];
        end
        apply_row(sel, col, hold);
      end
      if (f % 20 == 19) check_all("rand_rows");
    end

    // Randomized countdown traffic.
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      if (k < 5 && m_last_seg > 0) code = seg_al[m_last_seg - 1];
      else if (k < 8)              code = seg_al[$urandom_range(0, 15)];
      else                         code = 7'($urandom_range(0, 127));
      apply_seg(code, $urandom_range(1, 3));
      if (n % 50 == 49) check_all("rand_seg");
    end

    check_all("final");
    check("final.frames_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
